// File: rtl/boot_prog_ctrl.sv
// UART boot loader: takes a length-prefixed little-endian word stream and writes it
// into instruction memory while holding the core in reset. Optional macro PROG_CHKSUM_EN.
module boot_prog_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: rx_valid_i is a one-cycle strobe with no backpressure (a byte is
  // consumed the cycle it is seen). mem_req_o with addr/wdata is held stable until
  // mem_gnt_i; a write transfers in exactly the cycle where mem_req_o && mem_gnt_i.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef PROG_CHKSUM_EN
    CHK   = 3'd4,
`endif
    DONE  = 3'd5,
    ERR   = 3'd6,
    RUN   = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [32:0]       LEN_MAX  = 33'd1 << ADDR_W;

`ifdef PROG_CHKSUM_EN
  localparam state_t LAST_ST = CHK;
`else
  localparam state_t LAST_ST = DONE;
`endif

  state_t              state_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         shift_q;
  logic [ADDR_W:0]     remain_q;
  logic                overrun_q;
  logic                abort_q;
  logic                prog_q;
`ifdef PROG_CHKSUM_EN
  logic [7:0]          chk_q;
`endif

  logic [31:0] word_next;
  logic        too_long;
  logic        start_load;

  // Bytes arrive LSB first, so the newest byte lands in the top lane.
  assign word_next   = {rx_data_i, shift_q};
  assign too_long    = {1'b0, word_next} > LEN_MAX;
  assign start_load  = ((state_q == IDLE) && prog_i) ||
                       (((state_q == RUN) || (state_q == ERR)) && prog_i && !prog_q);
  assign mem_we_o    = mem_req_o;
  assign dbg_state_o = state_q;

  // Status flags packed as {core_rst, busy, done, err}.
  function automatic logic [3:0] flags_of(state_t s);
    case (s)
      LEN, DATA, WRITE: return 4'b1100;
`ifdef PROG_CHKSUM_EN
      CHK:              return 4'b1100;
`endif
      DONE:             return 4'b1010;
      ERR:              return 4'b1001;
      RUN:              return 4'b0000;
      default:          return 4'b1000;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      {core_rst_o, busy_o, done_o, err_o} <= flags_of(IDLE);
      mem_req_o   <= 1'b0;
      mem_addr_o  <= BASE;
      mem_wdata_o <= 32'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      remain_q    <= '0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
      prog_q      <= 1'b0;
`ifdef PROG_CHKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      prog_q <= prog_i;
      if (start_load) begin
        state_q    <= LEN;
        {core_rst_o, busy_o, done_o, err_o} <= flags_of(LEN);
        mem_req_o  <= 1'b0;
        mem_addr_o <= BASE;
        byte_cnt_q <= 2'd0;
        shift_q    <= 24'd0;
        remain_q   <= '0;
        overrun_q  <= 1'b0;
        abort_q    <= 1'b0;
`ifdef PROG_CHKSUM_EN
        chk_q      <= 8'd0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= RUN;
            {core_rst_o, busy_o, done_o, err_o} <= flags_of(RUN);
          end
          LEN: begin
            if (!prog_i) begin
              state_q <= ERR;
              {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
            end else if (rx_valid_i) begin
              shift_q    <= word_next[31:8];
              byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PROG_CHKSUM_EN
              chk_q      <= chk_q ^ rx_data_i;
`endif
              if (byte_cnt_q == 2'd3) begin
                if (word_next == 32'd0) begin
                  state_q <= LAST_ST;
                  {core_rst_o, busy_o, done_o, err_o} <= flags_of(LAST_ST);
                end else if (too_long) begin
                  state_q <= ERR;
                  {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
                end else begin
                  state_q    <= DATA;
                  {core_rst_o, busy_o, done_o, err_o} <= flags_of(DATA);
                  remain_q   <= (ADDR_W+1)'(word_next);
                  mem_addr_o <= BASE;
                end
              end
            end
          end
          DATA: begin
            // A partial word is simply dropped when the strap falls.
            if (!prog_i) begin
              state_q <= ERR;
              {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
            end else if (rx_valid_i) begin
              shift_q    <= word_next[31:8];
              byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PROG_CHKSUM_EN
              chk_q      <= chk_q ^ rx_data_i;
`endif
              if (byte_cnt_q == 2'd3) begin
                state_q     <= WRITE;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(WRITE);
                mem_wdata_o <= word_next;
                mem_req_o   <= 1'b1;
              end
            end
          end
          WRITE: begin
            // Overrun bytes and strap drops are remembered; the pending write still completes.
            if (rx_valid_i) overrun_q <= 1'b1;
            if (!prog_i)    abort_q   <= 1'b1;
            if (mem_gnt_i) begin
              mem_req_o  <= 1'b0;
              mem_addr_o <= mem_addr_o + ADDR_ONE;
              remain_q   <= remain_q - REM_ONE;
              if (overrun_q || rx_valid_i || abort_q || !prog_i) begin
                state_q <= ERR;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
              end else if (remain_q == REM_ONE) begin
                state_q <= LAST_ST;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(LAST_ST);
              end else begin
                state_q <= DATA;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(DATA);
              end
            end
          end
`ifdef PROG_CHKSUM_EN
          CHK: begin
            if (!prog_i) begin
              state_q <= ERR;
              {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
            end else if (rx_valid_i) begin
              if (rx_data_i == chk_q) begin
                state_q <= DONE;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(DONE);
              end else begin
                state_q <= ERR;
                {core_rst_o, busy_o, done_o, err_o} <= flags_of(ERR);
              end
            end
          end
`endif
          DONE: begin
            if (!prog_i) begin
              state_q <= RUN;
              {core_rst_o, busy_o, done_o, err_o} <= flags_of(RUN);
            end
          end
          ERR, RUN: begin
          end
          default: begin
            state_q <= IDLE;
            {core_rst_o, busy_o, done_o, err_o} <= flags_of(IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_prog_ctrl.sv
// Directed bench for boot_prog_ctrl: auto-granting memory responder, write log
// compared against an expected queue, one task per scenario.
module tb_boot_prog_ctrl;

  localparam int ADDR_W = 12;
  localparam int W      = ADDR_W + 32;
  localparam logic [ADDR_W-1:0] BASE = 12'h100;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;
  localparam logic [2:0] S_RUN  = 3'd7;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              prog_i = 1'b0;
  logic              rx_valid_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  logic              mem_gnt_i = 1'b0;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [2:0]        dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           cyc_q[$];
  int           gnt_delay = 0;
  int           gnt_cnt = 0;
  int           unstable_cnt = 0;
  logic [ADDR_W-1:0] snap_addr;
  logic [31:0]       snap_data;

  boot_prog_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prog_i(prog_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Memory responder: grants after gnt_delay waiting cycles and logs each write.
  always @(negedge clk_i) begin
    if (rst_i || mem_req_o !== 1'b1) begin
      mem_gnt_i = 1'b0;
      gnt_cnt   = 0;
    end else begin
      if (gnt_cnt == 0) begin
        snap_addr = mem_addr_o;
        snap_data = mem_wdata_o;
      end else if (mem_addr_o !== snap_addr || mem_wdata_o !== snap_data || mem_we_o !== 1'b1) begin
        unstable_cnt++;
      end
      if (gnt_cnt == gnt_delay) begin
        mem_gnt_i = 1'b1;
        obs_q.push_back({mem_addr_o, mem_wdata_o});
        cyc_q.push_back(gnt_cnt + 1);
      end else begin
        mem_gnt_i = 1'b0;
      end
      gnt_cnt++;
    end
  end

  // Driver tasks
  task automatic do_reset(input logic p);
    rx_valid_i = 1'b0;
    prog_i     = p;
    rst_i      = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    cyc_q.delete();
    unstable_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_req_clear(input string name);
    int n = 0;
    while (mem_req_o === 1'b1 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_timeout: mem_req_o=%b required 0 within 60 cycles", name, mem_req_o);
    end
  endtask

  // Scenarios
  task automatic test_reset;
    prog_i = 1'b0;
    rst_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    checks += 9;
    if (mem_req_o !== 1'b0)    begin errors++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    if (mem_we_o !== 1'b0)     begin errors++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
    if (mem_addr_o !== BASE)   begin errors++; $display("FAIL rst_addr: got %h want %h", mem_addr_o, BASE); end
    if (mem_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata_o); end
    if (core_rst_o !== 1'b1)   begin errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst_o); end
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    if (done_o !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
    if (err_o !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state_o, S_IDLE); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks += 2;
    if (dbg_state_o !== S_RUN) begin errors++; $display("FAIL idle_to_run_state: got %0d want %0d", dbg_state_o, S_RUN); end
    if (core_rst_o !== 1'b0)   begin errors++; $display("FAIL idle_to_run_core_rst: got %b want 0", core_rst_o); end
  endtask

  task automatic test_basic;
    do_reset(1'b1);
    gnt_delay = 0;
    send_word(32'd2);
    checks += 2;
    if (dbg_state_o !== S_DATA) begin errors++; $display("FAIL basic_len_state: got %0d want %0d", dbg_state_o, S_DATA); end
    if (busy_o !== 1'b1)        begin errors++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    exp_q.push_back({BASE, 32'h12345678});
    exp_q.push_back({BASE + 12'd1, 32'hDEADBEEF});
    send_word(32'h12345678);
    wait_req_clear("basic_w0");
    send_word(32'hDEADBEEF);
    wait_req_clear("basic_w1");
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks += 3;
    if (done_o !== 1'b1)        begin errors++; $display("FAIL basic_done: got %b want 1", done_o); end
    if (core_rst_o !== 1'b1)    begin errors++; $display("FAIL basic_done_core_rst: got %b want 1", core_rst_o); end
    if (dbg_state_o !== S_DONE) begin errors++; $display("FAIL basic_done_state: got %0d want %0d", dbg_state_o, S_DONE); end
    prog_i = 1'b0;
    @(negedge clk_i);
    checks += 3;
    if (core_rst_o !== 1'b0)   begin errors++; $display("FAIL basic_run_core_rst: got %b want 0", core_rst_o); end
    if (done_o !== 1'b0)       begin errors++; $display("FAIL basic_run_done: got %b want 0", done_o); end
    if (dbg_state_o !== S_RUN) begin errors++; $display("FAIL basic_run_state: got %0d want %0d", dbg_state_o, S_RUN); end
  endtask

  task automatic test_back_to_back;
    // Reload from RUN: address restarts at BASE.
    obs_q.delete();
    exp_q.delete();
    cyc_q.delete();
    gnt_delay = 2;
    prog_i = 1'b1;
    send_word(32'd1);
    exp_q.push_back({BASE, 32'hCAFEF00D});
    send_word(32'hCAFEF00D);
    wait_req_clear("reload");
    checks += 4;
    if (obs_q.size() != 1) begin errors++; $display("FAIL reload_write_count: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL reload_write: got %h want %h", obs_q[0], exp_q[0]); end
    if (cyc_q.size() != 1 || cyc_q[0] != 3) begin errors++; $display("FAIL reload_req_cycles: got %0d entries want one of 3", cyc_q.size()); end
    if (done_o !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done_o); end
    if (dbg_state_o !== S_DONE) begin errors++; $display("FAIL reload_state: got %0d want %0d", dbg_state_o, S_DONE); end
  endtask

  task automatic test_delayed_grant;
    do_reset(1'b1);
    gnt_delay = 5;
    exp_q.push_back({BASE, 32'h12345678});
    exp_q.push_back({BASE + 12'd1, 32'hDEADBEEF});
    send_word(32'd2);
    send_word(32'h12345678);
    wait_req_clear("slow_w0");
    send_word(32'hDEADBEEF);
    wait_req_clear("slow_w1");
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL slow_write_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      checks += 2;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL slow_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      if (cyc_q[i] != 6) begin errors++; $display("FAIL slow_req_cycles%0d: got %0d want 6", i, cyc_q[i]); end
    end
    checks += 2;
    if (unstable_cnt != 0) begin errors++; $display("FAIL slow_stable: got %0d changes want 0", unstable_cnt); end
    if (done_o !== 1'b1)   begin errors++; $display("FAIL slow_done: got %b want 1", done_o); end
  endtask

  task automatic test_overrun;
    do_reset(1'b1);
    gnt_delay = 4;
    exp_q.push_back({BASE, 32'h11223344});
    send_word(32'd2);
    send_word(32'h11223344);
    send_byte(8'h55);
    wait_req_clear("overrun");
    @(negedge clk_i);
    checks += 4;
    if (err_o !== 1'b1)        begin errors++; $display("FAIL overrun_err: got %b want 1", err_o); end
    if (core_rst_o !== 1'b1)   begin errors++; $display("FAIL overrun_core_rst: got %b want 1", core_rst_o); end
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL overrun_busy: got %b want 0", busy_o); end
    if (dbg_state_o !== S_ERR) begin errors++; $display("FAIL overrun_state: got %0d want %0d", dbg_state_o, S_ERR); end
    send_word(32'h99887766);
    repeat (8) @(negedge clk_i);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL overrun_write_count: got %0d want 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL overrun_write: got %h want %h", obs_q[0], exp_q[0]); end
    end
    prog_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    prog_i = 1'b1;
    @(negedge clk_i);
    checks += 3;
    if (dbg_state_o !== S_LEN) begin errors++; $display("FAIL err_reload_state: got %0d want %0d", dbg_state_o, S_LEN); end
    if (busy_o !== 1'b1)       begin errors++; $display("FAIL err_reload_busy: got %b want 1", busy_o); end
    if (err_o !== 1'b0)        begin errors++; $display("FAIL err_reload_err: got %b want 0", err_o); end
  endtask

  task automatic test_length_bounds;
    do_reset(1'b1);
    gnt_delay = 0;
    send_word(32'h00001001);
    repeat (3) @(negedge clk_i);
    checks += 3;
    if (err_o !== 1'b1)        begin errors++; $display("FAIL len4097_err: got %b want 1", err_o); end
    if (dbg_state_o !== S_ERR) begin errors++; $display("FAIL len4097_state: got %0d want %0d", dbg_state_o, S_ERR); end
    if (obs_q.size() != 0)     begin errors++; $display("FAIL len4097_writes: got %0d want 0", obs_q.size()); end
    do_reset(1'b1);
    send_word(32'h00001000);
    checks += 2;
    if (dbg_state_o !== S_DATA) begin errors++; $display("FAIL len4096_state: got %0d want %0d", dbg_state_o, S_DATA); end
    if (err_o !== 1'b0)         begin errors++; $display("FAIL len4096_err: got %b want 0", err_o); end
    do_reset(1'b1);
    send_word(32'd0);
    checks += 2;
`ifdef PROG_CHKSUM_EN
    if (dbg_state_o !== S_CHK) begin errors++; $display("FAIL len0_state: got %0d want %0d", dbg_state_o, S_CHK); end
    if (busy_o !== 1'b1)       begin errors++; $display("FAIL len0_busy: got %b want 1", busy_o); end
`else
    if (dbg_state_o !== S_DONE) begin errors++; $display("FAIL len0_state: got %0d want %0d", dbg_state_o, S_DONE); end
    if (done_o !== 1'b1)        begin errors++; $display("FAIL len0_done: got %b want 1", done_o); end
`endif
  endtask

  task automatic test_prog_drop;
    do_reset(1'b1);
    gnt_delay = 0;
    send_word(32'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    prog_i = 1'b0;
    @(negedge clk_i);
    checks += 2;
    if (err_o !== 1'b1)        begin errors++; $display("FAIL drop_err: got %b want 1", err_o); end
    if (dbg_state_o !== S_ERR) begin errors++; $display("FAIL drop_state: got %0d want %0d", dbg_state_o, S_ERR); end
    send_byte(8'hA3);
    send_byte(8'hA4);
    repeat (4) @(negedge clk_i);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL drop_writes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    gnt_delay = 0;
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_i = 1'b1;
    #1;
    checks += 5;
    if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state_o, S_IDLE); end
    if (busy_o !== 1'b0)        begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    if (core_rst_o !== 1'b1)    begin errors++; $display("FAIL midrst_core_rst: got %b want 1", core_rst_o); end
    if (mem_addr_o !== BASE)    begin errors++; $display("FAIL midrst_addr: got %h want %h", mem_addr_o, BASE); end
    if (err_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: got err=%b done=%b want 0 0", err_o, done_o); end
    do_reset(1'b1);
    gnt_delay = 100;
    send_word(32'd1);
    send_word(32'hAABBCCDD);
    checks++;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL midwr_req_before: got %b want 1", mem_req_o); end
    #2 rst_i = 1'b1;
    #1;
    checks += 3;
    if (mem_req_o !== 1'b0)    begin errors++; $display("FAIL midwr_req: got %b want 0", mem_req_o); end
    if (mem_we_o !== 1'b0)     begin errors++; $display("FAIL midwr_we: got %b want 0", mem_we_o); end
    if (mem_wdata_o !== 32'd0) begin errors++; $display("FAIL midwr_wdata: got %h want 0", mem_wdata_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    gnt_delay = 0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midwr_writes: got %0d want 0", obs_q.size()); end
  endtask

`ifdef PROG_CHKSUM_EN
  task automatic test_checksum;
    do_reset(1'b1);
    gnt_delay = 0;
    exp_q.push_back({BASE, 32'h000000AA});
    send_word(32'd1);
    send_word(32'h000000AA);
    wait_req_clear("chk_ok");
    send_byte(8'hAB);
    checks += 3;
    if (done_o !== 1'b1) begin errors++; $display("FAIL chk_ok_done: got %b want 1", done_o); end
    if (obs_q.size() != 1) begin errors++; $display("FAIL chk_ok_writes: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL chk_ok_write: got %h want %h", obs_q[0], exp_q[0]); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL chk_ok_err: got %b want 0", err_o); end
    do_reset(1'b1);
    send_word(32'd1);
    send_word(32'h000000AA);
    wait_req_clear("chk_bad");
    send_byte(8'h00);
    checks += 2;
    if (err_o !== 1'b1)  begin errors++; $display("FAIL chk_bad_err: got %b want 1", err_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL chk_bad_done: got %b want 0", done_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_delayed_grant();
    test_overrun();
    test_length_bounds();
    test_prog_drop();
    test_reset_mid();
`ifdef PROG_CHKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
